// File: rtl/fw_power_buffer.sv
// Frame power buffer: squares complex samples into a power memory and tracks the peak bin
// within a configurable search window. Registered read port with 2-cycle latency.
module fw_power_buffer #(
    parameter int unsigned N        = 32,
    parameter int unsigned N1       = 80,
    parameter int unsigned NUM_BINS = 512,
    parameter int unsigned MIN_BIN  = 16,
    parameter int unsigned MAX_BIN  = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          startfw,
    input  logic          in_valid,
    input  logic [N-1:0]  in_real,
    input  logic [N-1:0]  in_imag,
    input  logic [9:0]    addr_fw_real,
    output logic [N1-1:0] out_fw_real,
    output logic [N1-1:0] gmax,
    output logic [9:0]    gmax_bin,
    output logic          busyfw,
    output logic          donefw
);

    localparam int unsigned AW = $clog2(NUM_BINS);
    localparam int unsigned SW = 2 * (N - 1);

    localparam logic [9:0] NB_L     = 10'(NUM_BINS);
    localparam logic [9:0] LAST_IDX = 10'(NUM_BINS - 1);
    localparam logic [9:0] MIN_L    = 10'(MIN_BIN);
    localparam logic [9:0] MAX_L    = 10'(MAX_BIN);

    localparam logic [N-1:0] MAG_MASK = {1'b0, {(N - 1){1'b1}}};

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]    state;
    logic          drain_cnt;
    logic [9:0]    idx;
    logic          accept;
    logic          start;

    logic          s1_valid;
    logic [9:0]    s1_idx;
    logic [SW-1:0] sq_re;
    logic [SW-1:0] sq_im;
    logic [N-1:0]  re_mag;
    logic [N-1:0]  im_mag;
    logic [SW:0]   pw_sum;
    logic [N1-1:0] pw;
    logic          in_window;

    logic [9:0]    addr_q;
    logic [N1-1:0] mem [NUM_BINS];

    assign accept = (state == CAPTURE) && in_valid;
    assign start  = (state == IDLE) && startfw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            drain_cnt <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (startfw) begin
                        state <= CAPTURE;
                        idx   <= '0;
                    end
                end
                CAPTURE: begin
                    if (in_valid) begin
                        idx <= idx + 10'd1;
                        if (idx == LAST_IDX) begin
                            state     <= DRAIN;
                            drain_cnt <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // Two cycles here let the last sample clear both pipeline stages.
                    drain_cnt <= 1'b1;
                    if (drain_cnt) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= accept;
            s1_idx   <= idx;
        end
    end

    assign re_mag = in_real & MAG_MASK;
    assign im_mag = in_imag & MAG_MASK;

    always_ff @(posedge clk) begin
        sq_re <= SW'(re_mag) * SW'(re_mag);
        sq_im <= SW'(im_mag) * SW'(im_mag);
    end

    assign pw_sum    = {1'b0, sq_re} + {1'b0, sq_im};
    assign pw        = N1'(pw_sum >> 16);
    assign in_window = (s1_idx >= MIN_L) && (s1_idx <= MAX_L);

    // Strict compare keeps the lowest bin on ties.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gmax     <= '0;
            gmax_bin <= MIN_L;
        end else if (start) begin
            gmax     <= '0;
            gmax_bin <= MIN_L;
        end else if (s1_valid && in_window && (pw > gmax)) begin
            gmax     <= pw;
            gmax_bin <= s1_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_valid && (s1_idx < NB_L)) mem[s1_idx[AW-1:0]] <= pw;
    end

    // Nonblocking read of mem gives read-before-write on a same-edge collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q      <= '0;
            out_fw_real <= '0;
        end else begin
            addr_q      <= addr_fw_real;
            out_fw_real <= (addr_q < NB_L) ? mem[addr_q[AW-1:0]] : '0;
        end
    end

    assign busyfw = (state == CAPTURE) || (state == DRAIN);
    assign donefw = (state == DONE);

endmodule

// File: tb/tb_fw_power_buffer.sv
// Directed self-checking bench for fw_power_buffer: ramp, signs/ties, read latency,
// gapped stream with ignored start, and reset mid-frame.
module tb_fw_power_buffer;

    localparam int NB = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        startfw = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_real = '0;
    logic [31:0] in_imag = '0;
    logic [9:0]  addr = '0;
    logic [79:0] out_fw_real;
    logic [79:0] gmax;
    logic [9:0]  gmax_bin;
    logic        busyfw;
    logic        donefw;

    int checks = 0;
    int failures = 0;

    logic [31:0] re_v [NB];
    logic [31:0] im_v [NB];

    fw_power_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .startfw      (startfw),
        .in_valid     (in_valid),
        .in_real      (in_real),
        .in_imag      (in_imag),
        .addr_fw_real (addr),
        .out_fw_real  (out_fw_real),
        .gmax         (gmax),
        .gmax_bin     (gmax_bin),
        .busyfw       (busyfw),
        .donefw       (donefw)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] ramp_pw(input int i);
        logic [79:0] e;
        e = 80'(i * i);
        return e << 16;
    endfunction

    task automatic fill_ramp();
        for (int i = 0; i < NB; i++) begin
            re_v[i] = 32'(i) << 16;
            im_v[i] = '0;
        end
    endtask

    task automatic run_frame(input bit gapped, input bit mid_start, output int lat,
                             output int pulses);
        @(negedge clk);
        startfw = 1'b1;
        @(negedge clk);
        startfw = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (gapped) begin
                in_valid = 1'b0;
                startfw  = mid_start && (i == 200);
                @(negedge clk);
                startfw  = 1'b0;
            end
            in_valid = 1'b1;
            in_real  = re_v[i];
            in_imag  = im_v[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        lat      = -1;
        pulses   = 0;
        for (int c = 1; c <= 20; c++) begin
            if (donefw) begin
                pulses++;
                if (lat < 0) lat = c;
            end
            @(negedge clk);
        end
    endtask

    task automatic read_mem(input logic [9:0] a, output logic [79:0] d);
        @(negedge clk);
        addr = a;
        @(negedge clk);
        @(negedge clk);
        d = out_fw_real;
    endtask

    initial begin
        int          lat;
        int          pulses;
        logic [79:0] d;

        repeat (3) @(negedge clk);
        check_eq("rst_busy", 80'(busyfw), 80'd0);
        check_eq("rst_done", 80'(donefw), 80'd0);
        check_eq("rst_gmax", gmax, 80'd0);
        check_eq("rst_gbin", 80'(gmax_bin), 80'd16);
        check_eq("rst_out", out_fw_real, 80'd0);
        rst = 1'b1;

        // Ramp frame
        fill_ramp();
        run_frame(1'b0, 1'b0, lat, pulses);
        check_eq("ramp_lat", 80'(lat), 80'd3);
        check_eq("ramp_pulses", 80'(pulses), 80'd1);
        check_eq("ramp_gmax", gmax, 80'h4000_0000);
        check_eq("ramp_gbin", 80'(gmax_bin), 80'd128);
        check_eq("ramp_busy", 80'(busyfw), 80'd0);
        read_mem(10'd0, d);   check_eq("ramp_m0", d, ramp_pw(0));
        read_mem(10'd1, d);   check_eq("ramp_m1", d, ramp_pw(1));
        read_mem(10'd128, d); check_eq("ramp_m128", d, ramp_pw(128));
        read_mem(10'd511, d); check_eq("ramp_m511", d, ramp_pw(511));

        // Read latency: addr 7 then 8 on consecutive edges
        @(negedge clk);
        addr = 10'd7;
        @(negedge clk);
        addr = 10'd8;
        @(negedge clk);
        check_eq("lat_m7", out_fw_real, ramp_pw(7));
        @(negedge clk);
        check_eq("lat_m8", out_fw_real, ramp_pw(8));
        read_mem(10'd600, d); check_eq("rd_oob", d, 80'd0);

        // Signs and ties
        for (int i = 0; i < NB; i++) begin
            re_v[i] = '0;
            im_v[i] = '0;
        end
        re_v[40] = 32'h8003_0000; im_v[40] = 32'h0004_0000;
        re_v[60] = 32'h0003_0000; im_v[60] = 32'h8004_0000;
        re_v[5]  = 32'h0064_0000;
        run_frame(1'b0, 1'b0, lat, pulses);
        check_eq("sign_lat", 80'(lat), 80'd3);
        check_eq("sign_gmax", gmax, 80'h19_0000);
        check_eq("sign_gbin", 80'(gmax_bin), 80'd40);
        read_mem(10'd5, d);  check_eq("sign_m5", d, 80'd10000 << 16);
        read_mem(10'd60, d); check_eq("sign_m60", d, 80'h19_0000);
        read_mem(10'd6, d);  check_eq("sign_m6", d, 80'd0);

        // Gapped stream with ignored mid-frame start
        fill_ramp();
        run_frame(1'b1, 1'b1, lat, pulses);
        check_eq("gap_lat", 80'(lat), 80'd3);
        check_eq("gap_pulses", 80'(pulses), 80'd1);
        check_eq("gap_gmax", gmax, 80'h4000_0000);
        check_eq("gap_gbin", 80'(gmax_bin), 80'd128);
        read_mem(10'd300, d); check_eq("gap_m300", d, ramp_pw(300));
        read_mem(10'd511, d); check_eq("gap_m511", d, ramp_pw(511));

        // Reset mid-frame
        @(negedge clk);
        startfw = 1'b1;
        @(negedge clk);
        startfw = 1'b0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_real  = 32'h0007_0000;
            in_imag  = '0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_eq("pre_rst_busy", 80'(busyfw), 80'd1);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_busy", 80'(busyfw), 80'd0);
        check_eq("mid_rst_gmax", gmax, 80'd0);
        check_eq("mid_rst_gbin", 80'(gmax_bin), 80'd16);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            if (donefw) pulses++;
            @(negedge clk);
        end
        check_eq("mid_rst_nodone", 80'(pulses), 80'd0);
        read_mem(10'd300, d); check_eq("mem_kept", d, ramp_pw(300));
        read_mem(10'd50, d);  check_eq("mem_part", d, 80'd49 << 16);

        fill_ramp();
        run_frame(1'b0, 1'b0, lat, pulses);
        check_eq("fresh_lat", 80'(lat), 80'd3);
        check_eq("fresh_gmax", gmax, 80'h4000_0000);
        check_eq("fresh_gbin", 80'(gmax_bin), 80'd128);
        read_mem(10'd50, d); check_eq("fresh_m50", d, ramp_pw(50));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fw_power_buffer.md
FW_POWER_BUFFER -- requirements
Module: fw_power_buffer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  N  32  input sample width; sign-magnitude Q16, laid out 1 sign, 15 integer, 16 fraction bits
  N1  80  stored power word width, Q16
  NUM_BINS  512  samples accepted per frame
  MIN_BIN  16  lowest bin included in the peak search
  MAX_BIN  128  highest bin included in the peak search
REQ-002 Ports, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all logic on its rising edge
  rst  in  1  asynchronous, active-low reset
  startfw  in  1  frame start request; sampled only in IDLE
  in_valid  in  1  sample strobe; one sample per high cycle while in CAPTURE
  in_real  in  N  real part of the sample
  in_imag  in  N  imaginary part of the sample
  addr_fw_real  in  10  read address
  out_fw_real  out  N1  read data for addr_fw_real
  gmax  out  N1  peak power within [MIN_BIN, MAX_BIN]
  gmax_bin  out  10  bin index of gmax
  busyfw  out  1  high from CAPTURE through DRAIN
  donefw  out  1  one-cycle pulse when the frame is complete

Function
REQ-003 The block SHALL hold an internal memory of NUM_BINS words, each N1 bits wide.
REQ-004 The FSM states SHALL be IDLE, CAPTURE, DRAIN and DONE.
REQ-005 FSM transitions SHALL be:
  IDLE->CAPTURE on startfw.
  CAPTURE->DRAIN in the cycle after the NUM_BINS-th accepted sample.
  DRAIN->DONE after 2 cycles.
  DONE->IDLE after 1 cycle.
REQ-006 Entering CAPTURE SHALL clear the sample index to 0, gmax to 0 and gmax_bin to MIN_BIN.
REQ-007 in_valid SHALL be ignored in IDLE, DRAIN and DONE; startfw SHALL be ignored outside IDLE.
REQ-008 Power pipeline, stage 1: register the square of in_real[N-2:0] and the square of in_imag[N-2:0], each 62 bits in Q32; the sign bit is discarded.
REQ-009 Power pipeline, stage 2:
  sum the two squares, shift right 16 bits to Q16, zero-extend to N1;
  write the result to mem[index] on the second rising edge after acceptance.
REQ-010 The sample index SHALL travel with the data through both pipeline stages.
REQ-011 The index SHALL increment by 1 per accepted sample; bins at or above NUM_BINS are never written.
REQ-012 Peak update in stage 2: if MIN_BIN <= index <= MAX_BIN and power > gmax (strict), gmax <= power and gmax_bin <= index. Ties therefore keep the lowest bin.
REQ-013 Read port:
  addr_fw_real registered at edge k;
  memory read into out_fw_real at edge k+1, so data is valid 2 cycles after the address is applied;
  reads are allowed in every state.
REQ-014 A read and a write to the same address on the same edge SHALL return the old content (read-before-write).
REQ-015 Reads with addr_fw_real >= NUM_BINS SHALL return 0.
REQ-016 donefw SHALL be high only in DONE, exactly one cycle, after the final write.
REQ-017 gmax and gmax_bin SHALL be stable from DONE until the next CAPTURE entry.
REQ-018 busyfw SHALL be high in CAPTURE and DRAIN.
REQ-019 A gap in in_valid SHALL stall nothing; the pipeline advances every cycle, with a valid bit per stage.

Reset
REQ-020 rst low SHALL immediately force:
  state IDLE;
  index and pipeline valid bits to 0;
  gmax and out_fw_real to 0;
  gmax_bin to MIN_BIN;
  busyfw and donefw to 0.
REQ-021 Memory contents SHALL not be cleared by reset; after a reset during CAPTURE, the frame is abandoned and no donefw is issued.

Verification
REQ-022 Ramp frame: sample i = (in_real = i.0, in_imag = 0), 512 samples back-to-back -> mem[i] = i^2 in Q16; gmax = 128^2 = 0x4000_0000 (Q16), gmax_bin = 128; donefw exactly 3 cycles after the last accept.
REQ-023 Signs and ties:
  bin 40 = (-3.0, +4.0) and bin 60 = (+3.0, -4.0), all other bins 0 -> gmax = 25.0 (0x19_0000), gmax_bin = 40;
  bin 5 = 100.0 -> bin 5 ignored by the peak search but stored.
REQ-024 Read latency: write a frame; apply addr 7 at edge k, then addr 8 at edge k+1 -> out_fw_real = mem[7] after edge k+1 and mem[8] after edge k+2; addr 600 -> 0.
REQ-025 Gapped stream: in_valid high on alternate cycles for 512 samples; a startfw pulse mid-frame -> results identical to REQ-022; the startfw pulse is ignored.
REQ-026 Reset mid-frame: assert rst after 100 samples -> busyfw = 0, gmax = 0, no donefw; a fresh frame afterwards completes correctly.
